// File: rtl/wx_alias_filter.sv
// wx_alias_filter
//   Merged W^X tracker and store guard. ITLB fills with X=1 record executable
//   physical pages (4 KiB pages or 4 MiB megapages); up to NPORT store
//   addresses per cycle are checked against them, with the verdict one cycle
//   later. Supports selective/global flush, a sticky overflow fail-safe, a
//   sticky boot lock and logging of denied stores.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   lock_i, override_i     boot lock request / pre-lock write override
//   ins_valid_i/ppn/mega   executable fill to track
//   flush_all_i            drop all entries and clear overflow
//   flush_pg_i/ppn         drop entries covering flush_ppn_i
//   wr_valid_i, wr_addr_i  per-port store check requests (port p at [p*PA_W +: PA_W])
//   rsp_valid_o, wr_allow_o per-port verdict, one cycle after the request
//   locked_o, overflow_o   sticky lock and fail-safe state
//   occupancy_o            number of valid entries
//   viol_cnt_o, viol_addr_o saturating denial count / PA of latest denial
module wx_alias_filter #(
    parameter int PA_W      = 32,
    parameter int PG_SHIFT  = 12,
    parameter int MEGA_BITS = 10,
    parameter int N         = 16,
    parameter int NPORT     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lock_i,
    input  logic                        override_i,
    input  logic                        ins_valid_i,
    input  logic [PA_W-PG_SHIFT-1:0]    ins_ppn_i,
    input  logic                        ins_mega_i,
    input  logic                        flush_all_i,
    input  logic                        flush_pg_i,
    input  logic [PA_W-PG_SHIFT-1:0]    flush_ppn_i,
    input  logic [NPORT-1:0]            wr_valid_i,
    input  logic [NPORT*PA_W-1:0]       wr_addr_i,
    output logic [NPORT-1:0]            rsp_valid_o,
    output logic [NPORT-1:0]            wr_allow_o,
    output logic                        locked_o,
    output logic                        overflow_o,
    output logic [$clog2(N+1)-1:0]      occupancy_o,
    output logic [CNT_W-1:0]            viol_cnt_o,
    output logic [PA_W-1:0]             viol_addr_o
);

    localparam int PPN_W  = PA_W - PG_SHIFT;
    localparam int OCC_W  = $clog2(N+1);
    localparam int SLOT_W = $clog2(N);

    // A megapage entry ignores the low MEGA_BITS of the PPN.
    function automatic logic hit_f(input logic v, input logic mega,
                                   input logic [PPN_W-1:0] ep, input logic [PPN_W-1:0] q);
        if (!v)
            return 1'b0;
        if (mega)
            return ep[PPN_W-1:MEGA_BITS] == q[PPN_W-1:MEGA_BITS];
        return ep == q;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W:0]   inc);
        logic [CNT_W:0] s;
        s = {1'b0, cnt} + inc;
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Tracker state
    logic [N-1:0]       r_valid;
    logic [N-1:0]       r_mega;
    logic [PPN_W-1:0]   r_ppn [N];
    logic               r_overflow;
    logic               r_locked;
    logic [OCC_W-1:0]   r_occ;

    // Response / log state
    logic [NPORT-1:0]   r_rsp_valid;
    logic [NPORT-1:0]   r_allow;
    logic [CNT_W-1:0]   r_viol_cnt;
    logic [PA_W-1:0]    r_viol_addr;

    // Check path
    logic               w_eff_override;
    logic [NPORT-1:0]   w_hit;
    logic [NPORT-1:0]   w_deny;
    logic [CNT_W:0]     w_deny_cnt;
    logic [PA_W-1:0]    w_deny_addr;
    logic [PPN_W-1:0]   w_port_ppn [NPORT];

    // Update path
    logic [N-1:0]       w_valid_flush;
    logic [N-1:0]       w_valid_fin;
    logic               w_covered;
    logic               w_slot_found;
    logic [SLOT_W-1:0]  w_slot;
    logic               w_ins_write;
    logic               w_overflow_nxt;
    logic [OCC_W-1:0]   w_occ_nxt;

    // ---- Stage 0: check requests against entries as they stood at the start of the cycle.
    // A same-cycle fill is bypassed in; a same-cycle flush is deliberately ignored so the
    // answer only ever errs towards denial.
    always_comb begin
        w_eff_override = override_i & ~r_locked & ~lock_i;
        w_hit          = '0;
        w_deny         = '0;
        w_deny_cnt     = '0;
        w_deny_addr    = r_viol_addr;
        for (int p = 0; p < NPORT; p++) begin
            w_port_ppn[p] = wr_addr_i[p*PA_W+PG_SHIFT +: PPN_W];
            for (int e = 0; e < N; e++)
                if (hit_f(r_valid[e], r_mega[e], r_ppn[e], w_port_ppn[p]))
                    w_hit[p] = 1'b1;
            if (hit_f(ins_valid_i, ins_mega_i, ins_ppn_i, w_port_ppn[p]))
                w_hit[p] = 1'b1;
            w_deny[p]  = wr_valid_i[p] & (w_hit[p] | r_overflow) & ~w_eff_override;
            w_deny_cnt = w_deny_cnt + (CNT_W+1)'(w_deny[p]);
        end
        // Descending scan so the lowest denied port wins.
        for (int p = NPORT-1; p >= 0; p--)
            if (w_deny[p])
                w_deny_addr = wr_addr_i[p*PA_W +: PA_W];
    end

    // Flush first, then insert into the post-flush view of the table.
    always_comb begin
        w_valid_flush = r_valid;
        if (flush_all_i)
            w_valid_flush = '0;
        else if (flush_pg_i)
            for (int e = 0; e < N; e++)
                if (hit_f(r_valid[e], r_mega[e], r_ppn[e], flush_ppn_i))
                    w_valid_flush[e] = 1'b0;

        w_covered = 1'b0;
        for (int e = 0; e < N; e++)
            if (r_mega[e] == ins_mega_i && hit_f(w_valid_flush[e], r_mega[e], r_ppn[e], ins_ppn_i))
                w_covered = 1'b1;

        w_slot_found = 1'b0;
        w_slot       = '0;
        for (int e = N-1; e >= 0; e--)
            if (!w_valid_flush[e]) begin
                w_slot_found = 1'b1;
                w_slot       = SLOT_W'(e);
            end

        w_ins_write    = ins_valid_i & ~w_covered & w_slot_found;
        w_overflow_nxt = (r_overflow & ~flush_all_i) | (ins_valid_i & ~w_covered & ~w_slot_found);

        w_valid_fin = w_valid_flush;
        w_occ_nxt   = '0;
        for (int e = 0; e < N; e++) begin
            if (w_ins_write && w_slot == SLOT_W'(e))
                w_valid_fin[e] = 1'b1;
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_fin[e]);
        end
    end

    // ---- Stage 1: registered verdicts, log and tracker control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_overflow  <= 1'b0;
            r_locked    <= 1'b0;
            r_occ       <= '0;
            r_rsp_valid <= '0;
            r_allow     <= '0;
            r_viol_cnt  <= '0;
            r_viol_addr <= '0;
        end else begin
            r_valid     <= w_valid_fin;
            r_overflow  <= w_overflow_nxt;
            r_locked    <= r_locked | lock_i;
            r_occ       <= w_occ_nxt;
            r_rsp_valid <= wr_valid_i;
            r_allow     <= wr_valid_i & ~w_deny;
            r_viol_cnt  <= sat_add(r_viol_cnt, w_deny_cnt);
            r_viol_addr <= w_deny_addr;
        end
    end

    // Entry payload is only meaningful under its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_ins_write) begin
            r_ppn[w_slot]  <= ins_ppn_i;
            r_mega[w_slot] <= ins_mega_i;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign wr_allow_o  = r_allow;
    assign locked_o    = r_locked;
    assign overflow_o  = r_overflow;
    assign occupancy_o = r_occ;
    assign viol_cnt_o  = r_viol_cnt;
    assign viol_addr_o = r_viol_addr;

endmodule

// File: tb/tb_wx_alias_filter.sv
module tb_wx_alias_filter;

    localparam int PA_W      = 32;
    localparam int PG_SHIFT  = 12;
    localparam int MEGA_BITS = 10;
    localparam int N         = 8;
    localparam int NPORT     = 2;
    localparam int CNT_W     = 5;
    localparam int PPN_W     = PA_W - PG_SHIFT;
    localparam int OCC_W     = $clog2(N+1);
    localparam int MAXC      = (1 << CNT_W) - 1;
    localparam int RW        = 2*NPORT + 2 + OCC_W + CNT_W + PA_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   lock_i, override_i;
    logic                   ins_valid_i, ins_mega_i;
    logic [PPN_W-1:0]       ins_ppn_i;
    logic                   flush_all_i, flush_pg_i;
    logic [PPN_W-1:0]       flush_ppn_i;
    logic [NPORT-1:0]       wr_valid_i;
    logic [NPORT*PA_W-1:0]  wr_addr_i;
    logic [NPORT-1:0]       rsp_valid_o, wr_allow_o;
    logic                   locked_o, overflow_o;
    logic [OCC_W-1:0]       occupancy_o;
    logic [CNT_W-1:0]       viol_cnt_o;
    logic [PA_W-1:0]        viol_addr_o;

    int n_chk  = 0;
    int n_pass = 0;

    wx_alias_filter #(
        .PA_W(PA_W), .PG_SHIFT(PG_SHIFT), .MEGA_BITS(MEGA_BITS),
        .N(N), .NPORT(NPORT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lock_i(lock_i), .override_i(override_i),
        .ins_valid_i(ins_valid_i), .ins_ppn_i(ins_ppn_i), .ins_mega_i(ins_mega_i),
        .flush_all_i(flush_all_i), .flush_pg_i(flush_pg_i), .flush_ppn_i(flush_ppn_i),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i),
        .rsp_valid_o(rsp_valid_o), .wr_allow_o(wr_allow_o), .locked_o(locked_o),
        .overflow_o(overflow_o), .occupancy_o(occupancy_o),
        .viol_cnt_o(viol_cnt_o), .viol_addr_o(viol_addr_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: an unordered set of at most N pages ----------------
    typedef struct packed { logic mega; logic [PPN_W-1:0] ppn; } ent_t;
    ent_t              m_q[$];
    bit                m_ovf, m_lock;
    int                m_cnt;
    logic [PA_W-1:0]   m_addr;
    logic [NPORT-1:0]  exp_rsp, exp_allow;

    function automatic bit covers(logic mega, logic [PPN_W-1:0] ep, logic [PPN_W-1:0] q);
        if (mega)
            return (ep >> MEGA_BITS) == (q >> MEGA_BITS);
        return ep == q;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_ovf = 0; m_lock = 0; m_cnt = 0; m_addr = '0;
        exp_rsp = '0; exp_allow = '0;
    endtask

    // Predict the outcome of the current inputs, then advance one clock.
    task automatic step();
        bit eff, hit, den, first, dup;
        int nden;
        logic [PA_W-1:0]  a;
        logic [PPN_W-1:0] pg;
        ent_t e;
        eff   = override_i && !m_lock && !lock_i;
        nden  = 0;
        first = 1;
        for (int p = 0; p < NPORT; p++) begin
            a   = wr_addr_i[p*PA_W +: PA_W];
            pg  = a[PA_W-1:PG_SHIFT];
            hit = 0;
            foreach (m_q[i]) if (covers(m_q[i].mega, m_q[i].ppn, pg)) hit = 1;
            if (ins_valid_i && covers(ins_mega_i, ins_ppn_i, pg)) hit = 1;
            den          = wr_valid_i[p] && (hit || m_ovf) && !eff;
            exp_rsp[p]   = wr_valid_i[p];
            exp_allow[p] = wr_valid_i[p] && !den;
            if (den) begin
                nden++;
                if (first) m_addr = a;
                first = 0;
            end
        end
        m_cnt = (m_cnt + nden > MAXC) ? MAXC : m_cnt + nden;
        if (lock_i) m_lock = 1;
        if (flush_all_i) begin
            m_q.delete();
            m_ovf = 0;
        end else if (flush_pg_i) begin
            for (int i = m_q.size()-1; i >= 0; i--)
                if (covers(m_q[i].mega, m_q[i].ppn, flush_ppn_i)) m_q.delete(i);
        end
        if (ins_valid_i) begin
            dup = 0;
            foreach (m_q[i])
                if (m_q[i].mega == ins_mega_i && covers(m_q[i].mega, m_q[i].ppn, ins_ppn_i)) dup = 1;
            if (!dup) begin
                if (m_q.size() < N) begin
                    e.mega = ins_mega_i;
                    e.ppn  = ins_ppn_i;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lock_i = 0; override_i = 0;
        ins_valid_i = 0; ins_ppn_i = '0; ins_mega_i = 0;
        flush_all_i = 0; flush_pg_i = 0; flush_ppn_i = '0;
        wr_valid_i = '0; wr_addr_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
    endtask

    task automatic store(input logic [NPORT-1:0] v, input logic [PA_W-1:0] a0, input logic [PA_W-1:0] a1);
        wr_valid_i = v;
        wr_addr_i  = {a1, a0};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        wr_valid_i = 2'b11;
        ins_valid_i = 1;
        lock_i = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({rsp_valid_o, wr_allow_o, locked_o, overflow_o, occupancy_o, viol_cnt_o, viol_addr_o} !== '0)
            $display("FAIL reset_outputs: got rsp=%b allow=%b lock=%b ovf=%b occ=%0d cnt=%0d addr=%h, want all 0",
                     rsp_valid_o, wr_allow_o, locked_o, overflow_o, occupancy_o, viol_cnt_o, viol_addr_o);
        else n_pass++;
        idle();
        rst_n = 1;
        model_clear();
    endtask

    task automatic test_empty();
        idle();
        store(2'b01, 32'h0800_4000, 32'h0);
        step();
        n_chk++;
        if (rsp_valid_o !== 2'b01) $display("FAIL empty_rsp: got %b want 01", rsp_valid_o); else n_pass++;
        n_chk++;
        if (wr_allow_o !== 2'b01) $display("FAIL empty_allow: got %b want 01", wr_allow_o); else n_pass++;
        n_chk++;
        if (viol_cnt_o !== 0) $display("FAIL empty_cnt: got %0d want 0", viol_cnt_o); else n_pass++;
    endtask

    task automatic test_insert_4k();
        idle();
        ins_valid_i = 1; ins_ppn_i = 20'h08004;
        step();
        idle();
        store(2'b11, 32'h0800_4010, 32'h0800_5000);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b10) $display("FAIL ins4k_allow: got %b want 10", wr_allow_o); else n_pass++;
        n_chk++;
        if (viol_cnt_o !== 1) $display("FAIL ins4k_cnt: got %0d want 1", viol_cnt_o); else n_pass++;
        n_chk++;
        if (viol_addr_o !== 32'h0800_4010) $display("FAIL ins4k_addr: got %h want 08004010", viol_addr_o); else n_pass++;
        n_chk++;
        if (occupancy_o !== 1) $display("FAIL ins4k_occ: got %0d want 1", occupancy_o); else n_pass++;
    endtask

    task automatic test_megapage();
        idle();
        ins_valid_i = 1; ins_ppn_i = 20'h08000; ins_mega_i = 1;
        step();
        idle();
        n_chk++;
        if (occupancy_o !== 2) $display("FAIL mega_occ: got %0d want 2", occupancy_o); else n_pass++;
        store(2'b11, 32'h083F_F000, 32'h0840_0000);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b10) $display("FAIL mega_allow: got %b want 10", wr_allow_o); else n_pass++;
        flush_pg_i = 1; flush_ppn_i = 20'h08123;
        step();
        idle();
        n_chk++;
        if (occupancy_o !== 1) $display("FAIL mega_flush_occ: got %0d want 1", occupancy_o); else n_pass++;
        store(2'b01, 32'h083F_F000, 32'h0);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b01) $display("FAIL mega_after_flush: got %b want 01", wr_allow_o); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < N; i++) begin
            ins_valid_i = 1; ins_ppn_i = 20'h30000 + PPN_W'(i);
            step();
        end
        idle();
        n_chk++;
        if (occupancy_o !== OCC_W'(N) || overflow_o !== 1'b0)
            $display("FAIL ovf_full: got occ=%0d ovf=%b want occ=%0d ovf=0", occupancy_o, overflow_o, N);
        else n_pass++;
        ins_valid_i = 1; ins_ppn_i = 20'h30000 + PPN_W'(N);
        step();
        idle();
        n_chk++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_o); else n_pass++;
        store(2'b01, 32'h1000_0000, 32'h0);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b00) $display("FAIL ovf_deny: got %b want 00", wr_allow_o); else n_pass++;
        flush_all_i = 1;
        step();
        idle();
        n_chk++;
        if (overflow_o !== 1'b0 || occupancy_o !== 0)
            $display("FAIL ovf_flush: got ovf=%b occ=%0d want 0/0", overflow_o, occupancy_o);
        else n_pass++;
        store(2'b01, 32'h1000_0000, 32'h0);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b01) $display("FAIL ovf_allow_after: got %b want 01", wr_allow_o); else n_pass++;
    endtask

    task automatic test_bypass_saturate();
        idle();
        ins_valid_i = 1; ins_ppn_i = 20'h20000;
        store(2'b01, 32'h2000_0000, 32'h0);
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b00 || rsp_valid_o !== 2'b01)
            $display("FAIL bypass: got allow=%b rsp=%b want 00/01", wr_allow_o, rsp_valid_o);
        else n_pass++;
        for (int k = 0; k < 64 && m_cnt < MAXC-1; k++) begin
            store(2'b01, 32'h2000_0040, 32'h0);
            step();
        end
        idle();
        n_chk++;
        if (viol_cnt_o !== CNT_W'(MAXC-1)) $display("FAIL sat_pre: got %0d want %0d", viol_cnt_o, MAXC-1); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            store(2'b11, 32'h2000_0010, 32'h2000_0020);
            step();
            idle();
            n_chk++;
            if (viol_cnt_o !== CNT_W'(MAXC) || viol_addr_o !== 32'h2000_0010)
                $display("FAIL sat_%0d: got cnt=%0d addr=%h want %0d/20000010", k, viol_cnt_o, viol_addr_o, MAXC);
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        do_reset();
        ins_valid_i = 1; ins_ppn_i = 20'h08004;
        step();
        idle();
        override_i = 1;
        store(2'b01, 32'h0800_4020, 32'h0);
        step();
        n_chk++;
        if (wr_allow_o !== 2'b01 || locked_o !== 1'b0)
            $display("FAIL lock_override: got allow=%b lock=%b want 01/0", wr_allow_o, locked_o);
        else n_pass++;
        lock_i = 1;
        step();
        n_chk++;
        if (wr_allow_o !== 2'b00 || locked_o !== 1'b1)
            $display("FAIL lock_same_cycle: got allow=%b lock=%b want 00/1", wr_allow_o, locked_o);
        else n_pass++;
        lock_i = 0;
        step();
        idle();
        n_chk++;
        if (wr_allow_o !== 2'b00 || locked_o !== 1'b1)
            $display("FAIL lock_sticky: got allow=%b lock=%b want 00/1", wr_allow_o, locked_o);
        else n_pass++;
    endtask

    function automatic logic [PPN_W-1:0] rand_ppn();
        return 20'h08000 + PPN_W'($urandom_range(0, 3) << MEGA_BITS) + PPN_W'($urandom_range(0, 11));
    endfunction

    task automatic test_random();
        logic [RW-1:0] got, exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ins_valid_i = ($urandom_range(0, 9) < 4);
            ins_mega_i  = ($urandom_range(0, 9) == 0);
            ins_ppn_i   = rand_ppn();
            flush_pg_i  = ($urandom_range(0, 9) == 0);
            flush_ppn_i = rand_ppn();
            flush_all_i = ($urandom_range(0, 39) == 0);
            override_i  = ($urandom_range(0, 4) == 0);
            lock_i      = (c > 400) && ($urandom_range(0, 49) == 0);
            wr_valid_i  = NPORT'($urandom_range(0, 3));
            wr_addr_i   = {rand_ppn(), 12'($urandom), rand_ppn(), 12'($urandom)};
            step();
            got = {rsp_valid_o, wr_allow_o, locked_o, overflow_o, occupancy_o, viol_cnt_o, viol_addr_o};
            exp = {exp_rsp, exp_allow, m_lock, m_ovf, OCC_W'(m_q.size()), CNT_W'(m_cnt), m_addr};
            n_chk++;
            if (got !== exp) $display("FAIL random_c%0d: got %h want %h", c, got, exp); else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_midop();
        idle();
        ins_valid_i = 1; ins_ppn_i = 20'h20000;
        store(2'b11, 32'h2000_0000, 32'h2000_0004);
        step();
        store(2'b11, 32'h2000_0000, 32'h2000_0004);
        #2;
        rst_n = 0;
        #1;
        n_chk++;
        if ({rsp_valid_o, wr_allow_o, locked_o, overflow_o, occupancy_o, viol_cnt_o, viol_addr_o} !== '0)
            $display("FAIL reset_midop: got rsp=%b allow=%b occ=%0d cnt=%0d, want all 0",
                     rsp_valid_o, wr_allow_o, occupancy_o, viol_cnt_o);
        else n_pass++;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1;
        model_clear();
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_clear();
        test_reset();
        test_empty();
        test_insert_4k();
        test_megapage();
        test_overflow();
        test_bypass_saturate();
        test_lock();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
